// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the 2-way set-associative data cache.
package dcache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_SETS   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_REFILL,
    S_REFILL_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty/data per set, combinational read at i_idx and
// a clocked write port (line fill has priority over a single-word store).
module dcache_way
  import dcache_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int SETS   = DEF_SETS,
  parameter int TAG_W  = DEF_ADDR_W - clog2(DEF_SETS) - clog2(DEF_LINE_W / 8)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [clog2(SETS)-1:0]        i_idx,
  output logic [TAG_W-1:0]              o_tag,
  output logic                          o_valid,
  output logic                          o_dirty,
  output logic [LINE_W-1:0]             o_line,
  input  logic                          i_fill_en,
  input  logic [TAG_W-1:0]              i_fill_tag,
  input  logic [LINE_W-1:0]             i_fill_line,
  input  logic                          i_word_en,
  input  logic [clog2(LINE_W/32)-1:0]   i_word_sel,
  input  logic [31:0]                   i_word_data
);

  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];
  logic [SETS-1:0]   r_valid;
  logic [SETS-1:0]   r_dirty;

  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_en) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data contents need no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (i_fill_en) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_line;
    end else if (i_word_en) begin
      r_data[i_idx][i_word_sel*32 +: 32] <= i_word_data;
    end
  end

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate data cache with 1-bit LRU.
// Optional hit/miss counters are built when DCACHE_PERF_EN is defined.
module dcache_2way_top
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int SETS   = DEF_SETS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W  = clog2(LINE_W / 8);
  localparam int IDX_W  = clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = LINE_W / 32;
  localparam int WSEL_W = clog2(WORDS);

  logic [WSEL_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_unused_ok;

  assign w_word      = p1_addr_i[OFF_W-1:2];
  assign w_idx       = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign w_tag       = p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign w_unused_ok = &{1'b0, p1_addr_i[1:0]};

  logic [TAG_W-1:0]  w_way_tag  [2];
  logic [LINE_W-1:0] w_way_line [2];
  logic [1:0]        w_way_valid;
  logic [1:0]        w_way_dirty;
  logic [1:0]        w_hit;
  logic [1:0]        w_fill_en;
  logic [1:0]        w_word_en;

  state_t             r_state, w_state_next;
  logic               r_victim, w_victim_next;
  logic [SETS-1:0]    r_lru;
  logic               r_mem_en, w_mem_en_next;
  logic               r_mem_wr, w_mem_wr_next;
  logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_next;
  logic [LINE_W-1:0]  r_mem_data, w_mem_data_next;

  for (genvar gi = 0; gi < 2; gi++) begin : g_way
    assign w_hit[gi]     = w_way_valid[gi] & (w_way_tag[gi] == w_tag);
    assign w_fill_en[gi] = (r_state == S_REFILL) & mem_ack_i & (r_victim == 1'(gi));
    assign w_word_en[gi] = p1_MemWrite_i & w_hit[gi];

    dcache_way #(
      .LINE_W (LINE_W),
      .SETS   (SETS),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_idx       (w_idx),
      .o_tag       (w_way_tag[gi]),
      .o_valid     (w_way_valid[gi]),
      .o_dirty     (w_way_dirty[gi]),
      .o_line      (w_way_line[gi]),
      .i_fill_en   (w_fill_en[gi]),
      .i_fill_tag  (w_tag),
      .i_fill_line (mem_data_i),
      .i_word_en   (w_word_en[gi]),
      .i_word_sel  (w_word),
      .i_word_data (p1_data_i)
    );
  end

  logic              w_req;
  logic              w_hit_any;
  logic              w_hit_way;
  logic              w_serve;
  logic [LINE_W-1:0] w_hit_line;

  assign w_req      = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit_any  = |w_hit;
  assign w_hit_way  = w_hit[1];
  assign w_hit_line = w_way_line[w_hit_way];
  assign p1_stall_o = w_req & ~w_hit_any;
  assign p1_data_o  = (w_req & w_hit_any) ? w_hit_line[w_word*32 +: 32] : 32'h0;
  // The post-refill retry is serviced in REFILL_DONE, so it ranks as a normal hit.
  assign w_serve    = w_req & w_hit_any & ((r_state == S_IDLE) | (r_state == S_REFILL_DONE));

  always_comb begin
    w_state_next    = r_state;
    w_victim_next   = r_victim;
    w_mem_en_next   = r_mem_en;
    w_mem_wr_next   = r_mem_wr;
    w_mem_addr_next = r_mem_addr;
    w_mem_data_next = r_mem_data;
    case (r_state)
      S_IDLE: begin
        if (w_req & ~w_hit_any) begin
          w_state_next = S_MISS;
          if (!w_way_valid[0])      w_victim_next = 1'b0;
          else if (!w_way_valid[1]) w_victim_next = 1'b1;
          else                      w_victim_next = r_lru[w_idx];
        end
      end
      S_MISS: begin
        w_mem_en_next = 1'b1;
        if (w_way_valid[r_victim] & w_way_dirty[r_victim]) begin
          w_mem_wr_next   = 1'b1;
          w_mem_addr_next = {w_way_tag[r_victim], w_idx, {OFF_W{1'b0}}};
          w_mem_data_next = w_way_line[r_victim];
          w_state_next    = S_WRITEBACK;
        end else begin
          w_mem_wr_next   = 1'b0;
          w_mem_addr_next = {w_tag, w_idx, {OFF_W{1'b0}}};
          w_state_next    = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          w_mem_wr_next   = 1'b0;
          w_mem_addr_next = {w_tag, w_idx, {OFF_W{1'b0}}};
          w_state_next    = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          w_mem_en_next = 1'b0;
          w_state_next  = S_REFILL_DONE;
        end
      end
      S_REFILL_DONE: w_state_next = S_IDLE;
      default:       w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_victim   <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_victim   <= w_victim_next;
      r_mem_en   <= w_mem_en_next;
      r_mem_wr   <= w_mem_wr_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_data <= w_mem_data_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_lru <= '0;
    else if (w_serve) r_lru[w_idx] <= ~w_hit_way;
  end

  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_wr;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

`ifdef DCACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_serve && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_state == S_IDLE && w_req && !w_hit_any && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed self-checking bench for dcache_2way_top (perf counters checked when
// DCACHE_PERF_EN is defined).
module tb_dcache_2way_top;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
`ifdef DCACHE_PERF_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  int passed = 0;
  int total  = 0;

  dcache_2way_top dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .p1_data_i     (p1_data_i),
    .p1_addr_i     (p1_addr_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o)
`ifdef DCACHE_PERF_EN
    ,
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Inputs change shortly after a negedge; outputs are sampled there too.
  task automatic set_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    @(negedge clk_i);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = data;
    #1;
  endtask

  // Memory model: wait (bounded) for a request, capture it, ack 3 cycles later.
  task automatic mem_serve(input logic [255:0] rdata, output bit ok, output logic we,
                           output logic [31:0] addr, output logic [255:0] wdata);
    ok = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    for (int n = 0; n < 20; n++) begin
      if (mem_enable_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) return;
    we    = mem_write_o;
    addr  = mem_addr_o;
    wdata = mem_data_o;
    repeat (2) @(negedge clk_i);
    mem_data_i = rdata;
    mem_ack_i  = 1'b1;
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    repeat (3) @(negedge clk_i);
    total++; if (mem_enable_o !== 1'b0) $display("FAIL rst_mem_en got=%b exp=0", mem_enable_o); else passed++;
    total++; if (mem_write_o !== 1'b0) $display("FAIL rst_mem_wr got=%b exp=0", mem_write_o); else passed++;
    total++; if (mem_addr_o !== 32'h0) $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_o); else passed++;
    total++; if (p1_stall_o !== 1'b0) $display("FAIL rst_stall_idle got=%b exp=0", p1_stall_o); else passed++;
    total++; if (p1_data_o !== 32'h0) $display("FAIL rst_data got=%h exp=0", p1_data_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    total++; if (p1_stall_o !== 1'b1) $display("FAIL rst_stall_cold got=%b exp=1", p1_stall_o); else passed++;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_cold_load;
    bit ok; logic we; logic [31:0] a; logic [255:0] wd; logic [255:0] line;
    line = mk_line(32'h0400_0000);
    line[63:32] = 32'hDEAD_BEEF;
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    total++; if (p1_stall_o !== 1'b1) $display("FAIL cold_stall got=%b exp=1", p1_stall_o); else passed++;
    mem_serve(line, ok, we, a, wd);
    total++; if (ok !== 1'b1) $display("FAIL cold_req_seen got=%b exp=1", ok); else passed++;
    total++; if (a !== 32'h0400) $display("FAIL cold_addr got=%h exp=00000400", a); else passed++;
    total++; if (we !== 1'b0) $display("FAIL cold_we got=%b exp=0", we); else passed++;
    total++; if (p1_stall_o !== 1'b0) $display("FAIL cold_retry_stall got=%b exp=0", p1_stall_o); else passed++;
    total++; if (p1_data_o !== 32'hDEAD_BEEF) $display("FAIL cold_data got=%h exp=deadbeef", p1_data_o); else passed++;
    total++; if (mem_enable_o !== 1'b0) $display("FAIL cold_en_drop got=%b exp=0", mem_enable_o); else passed++;
    $display("test_cold_load load 0x0404 -> %h", p1_data_o);
  endtask

  task automatic test_store_hit;
    // Both request lines set: treated as a store.
    set_req(1'b1, 1'b1, 32'h0404, 32'h1234_5678);
    total++; if (p1_stall_o !== 1'b0) $display("FAIL st_stall got=%b exp=0", p1_stall_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    total++; if (p1_stall_o !== 1'b0) $display("FAIL st_ld_stall got=%b exp=0", p1_stall_o); else passed++;
    total++; if (p1_data_o !== 32'h1234_5678) $display("FAIL st_ld_data got=%h exp=12345678", p1_data_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0408, 32'h0);
    total++; if (p1_data_o !== 32'h0400_0002) $display("FAIL st_neighbour got=%h exp=04000002", p1_data_o); else passed++;
    set_req(1'b0, 1'b0, 32'h0404, 32'h0);
    total++; if (p1_data_o !== 32'h0) $display("FAIL st_noreq_data got=%h exp=0", p1_data_o); else passed++;
    total++; if (mem_enable_o !== 1'b0) $display("FAIL st_no_mem got=%b exp=0", mem_enable_o); else passed++;
    $display("test_store_hit store/load 0x0404 -> 12345678 expected");
  endtask

  task automatic test_second_way;
    bit ok; logic we; logic [31:0] a; logic [255:0] wd;
    set_req(1'b1, 1'b0, 32'h0804, 32'h0);
    total++; if (p1_stall_o !== 1'b1) $display("FAIL w1_stall got=%b exp=1", p1_stall_o); else passed++;
    mem_serve(mk_line(32'h0800_0000), ok, we, a, wd);
    total++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h0800)
      $display("FAIL w1_refill got=ok%b we%b a%h exp=ok1 we0 a00000800", ok, we, a); else passed++;
    total++; if (p1_data_o !== 32'h0800_0001) $display("FAIL w1_data got=%h exp=08000001", p1_data_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    total++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h1234_5678)
      $display("FAIL w1_way0_hit got=s%b d%h exp=s0 d12345678", p1_stall_o, p1_data_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0804, 32'h0);
    total++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0800_0001)
      $display("FAIL w1_way1_hit got=s%b d%h exp=s0 d08000001", p1_stall_o, p1_data_o); else passed++;
    total++; if (mem_enable_o !== 1'b0) $display("FAIL w1_no_mem got=%b exp=0", mem_enable_o); else passed++;
    $display("test_second_way 0x0404/0x0804 both resident");
  endtask

  task automatic test_evict;
    bit ok; logic we; logic [31:0] a; logic [255:0] wd;
    set_req(1'b0, 1'b1, 32'h0404, 32'h1234_5678);
    set_req(1'b1, 1'b0, 32'h0804, 32'h0);
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    set_req(1'b1, 1'b0, 32'h0C04, 32'h0);
    total++; if (p1_stall_o !== 1'b1) $display("FAIL ev_c04_stall got=%b exp=1", p1_stall_o); else passed++;
    mem_serve(mk_line(32'h0C00_0000), ok, we, a, wd);
    total++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h0C00)
      $display("FAIL ev_clean_victim got=ok%b we%b a%h exp=ok1 we0 a00000c00", ok, we, a); else passed++;
    total++; if (p1_data_o !== 32'h0C00_0001) $display("FAIL ev_c04_data got=%h exp=0c000001", p1_data_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0804, 32'h0);
    mem_serve('0, ok, we, a, wd);
    total++; if (ok !== 1'b1 || we !== 1'b1 || a !== 32'h0400)
      $display("FAIL ev_writeback got=ok%b we%b a%h exp=ok1 we1 a00000400", ok, we, a); else passed++;
    total++; if (wd[63:32] !== 32'h1234_5678 || wd[31:0] !== 32'h0400_0000)
      $display("FAIL ev_wb_data got=%h_%h exp=12345678_04000000", wd[63:32], wd[31:0]); else passed++;
    total++; if (p1_stall_o !== 1'b1) $display("FAIL ev_wb_stall got=%b exp=1", p1_stall_o); else passed++;
    mem_serve(mk_line(32'h1800_0000), ok, we, a, wd);
    total++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h0800)
      $display("FAIL ev_refill got=ok%b we%b a%h exp=ok1 we0 a00000800", ok, we, a); else passed++;
    total++; if (p1_data_o !== 32'h1800_0001) $display("FAIL ev_804_data got=%h exp=18000001", p1_data_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0C04, 32'h0);
    total++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0C00_0001)
      $display("FAIL ev_c04_kept got=s%b d%h exp=s0 d0c000001", p1_stall_o, p1_data_o); else passed++;
    $display("test_evict dirty way 0 written back to 0x0400");
  endtask

  task automatic test_reset_mid_miss;
    bit ok; logic we; logic [31:0] a; logic [255:0] wd; bit seen;
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (mem_enable_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    total++; if (seen !== 1'b1) $display("FAIL rm_req_seen got=%b exp=1", seen); else passed++;
    rst_i = 1'b0;
    #1;
    total++; if (mem_enable_o !== 1'b0) $display("FAIL rm_async_drop got=%b exp=0", mem_enable_o); else passed++;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    total++; if (p1_stall_o !== 1'b1) $display("FAIL rm_invalidated got=%b exp=1", p1_stall_o); else passed++;
    mem_serve(mk_line(32'h0400_0000), ok, we, a, wd);
    total++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h0400)
      $display("FAIL rm_refill got=ok%b we%b a%h exp=ok1 we0 a00000400", ok, we, a); else passed++;
    total++; if (p1_data_o !== 32'h0400_0001) $display("FAIL rm_data got=%h exp=04000001", p1_data_o); else passed++;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    $display("test_reset_mid_miss reload 0x0404 -> %h", p1_data_o);
  endtask

`ifdef DCACHE_PERF_EN
  task automatic test_perf;
    bit ok; logic we; logic [31:0] a; logic [255:0] wd;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    total++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0)
      $display("FAIL perf_reset got=h%0d m%0d exp=h0 m0", hit_cnt_o, miss_cnt_o); else passed++;
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    mem_serve(mk_line(32'h0400_0000), ok, we, a, wd);
    total++; if (ok !== 1'b1) $display("FAIL perf_refill got=%b exp=1", ok); else passed++;
    set_req(1'b1, 1'b0, 32'h0404, 32'h0);
    set_req(1'b1, 1'b0, 32'h0408, 32'h0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (miss_cnt_o !== 32'd1) $display("FAIL perf_miss got=%0d exp=1", miss_cnt_o); else passed++;
    total++; if (hit_cnt_o !== 32'd3) $display("FAIL perf_hit got=%0d exp=3", hit_cnt_o); else passed++;
    $display("test_perf hits=%0d misses=%0d", hit_cnt_o, miss_cnt_o);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_second_way();
    test_evict();
    test_reset_mid_miss();
`ifdef DCACHE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
